// File: rtl/sdm_pkg.sv
// Shared sigma-delta definitions: CIC register width, bit-to-level mapping
// and default sample width / feedback magnitude used by modulator and decoder.
package sdm_pkg;

  localparam int SDM_DEFAULT_BITS = 12;
  localparam int SDM_DEFAULT_K    = 1024;

  // Level carried by each stream bit: 1 -> +1, 0 -> -1
  localparam int SDM_BIT_ONE  = 1;
  localparam int SDM_BIT_ZERO = -1;

  // CIC register width: enough headroom for R^N gain plus sign and one guard bit
  function automatic int sdm_cic_width(input int n, input int r);
    return 2 + n * $clog2(r);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator (differential delay 1) with valid in/out.
// The delay element only advances on a valid input, so idle cycles between
// decimated samples never disturb the difference.
module cic_comb_stage #(
  parameter int W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_data,
  output logic                o_valid,
  output logic signed [W-1:0] o_data
);

  logic signed [W-1:0] r_dly;
  logic signed [W-1:0] r_data;
  logic                r_valid;

  // Difference against the previous decimated sample, one register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data - r_dly;
        r_dly  <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/sdm_cic_decoder.sv
// Sigma-delta bitstream decoder: N inline integrators, decimation by R,
// N pipelined comb stages, scaling shift and reduction to a BITS-wide sample.
// Build option: define SDM_DEC_SAT_EN to saturate the scaled result instead of
// wrapping it to its low BITS bits.
module sdm_cic_decoder
  import sdm_pkg::*;
#(
  parameter int BITS = SDM_DEFAULT_BITS,
  parameter int K    = SDM_DEFAULT_K,
  parameter int R    = 64,
  parameter int N    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   y,
  input  logic                   y_valid,
  output logic signed [BITS-1:0] x,
  output logic                   x_valid
);

  localparam int W  = sdm_cic_width(N, R);
  localparam int LR = $clog2(R);
  // CIC gain is R^N; a full-scale stream must land on +K
  localparam int SH = N * LR - $clog2(K);
  localparam int WE = (W > BITS) ? W : BITS;

  logic [LR-1:0]       r_cnt;
  logic                r_strobe;
  logic signed [W-1:0] r_integ     [N];
  logic signed [W-1:0] w_integ_nxt [N];
  logic signed [W-1:0] w_step;
  logic signed [W-1:0] w_carry;

  logic [N:0]          w_cv;
  logic signed [W-1:0] w_cd [N+1];

  logic signed [W-1:0]    w_shift;
  logic signed [WE-1:0]   w_ext;
  logic signed [BITS-1:0] w_red;

  // Next integrator values: the new bit ripples through the whole cascade
  always_comb begin
    w_step  = y ? W'(SDM_BIT_ONE) : W'(SDM_BIT_ZERO);
    w_carry = w_step;
    for (int k = 0; k < N; k++) begin
      w_integ_nxt[k] = r_integ[k] + w_carry;
      w_carry        = w_integ_nxt[k];
    end
  end

  // Accept a bit: advance integrators and counter, strobe on the frame's last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_integ[k] <= '0;
      end
    end else begin
      r_strobe <= 1'b0;
      if (y_valid) begin
        for (int k = 0; k < N; k++) begin
          r_integ[k] <= w_integ_nxt[k];
        end
        r_cnt    <= r_cnt + LR'(1);
        r_strobe <= (r_cnt == LR'(R - 1));
      end
    end
  end

  assign w_cv[0] = r_strobe;
  assign w_cd[0] = r_integ[N-1];

  generate
    for (genvar g = 0; g < N; g++) begin : g_comb
      cic_comb_stage #(.W(W)) u_comb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_cv[g]),
        .i_data  (w_cd[g]),
        .o_valid (w_cv[g+1]),
        .o_data  (w_cd[g+1])
      );
    end
  endgenerate

`ifdef SDM_DEC_SAT_EN
  localparam logic signed [WE-1:0] SAT_MAX = {{(WE-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [WE-1:0] SAT_MIN = {{(WE-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
`endif

  // Scale the comb output and reduce it to the output sample width
  always_comb begin
    w_shift = w_cd[N] >>> SH;
    w_ext   = WE'(w_shift);
`ifdef SDM_DEC_SAT_EN
    if (w_ext > SAT_MAX) begin
      w_red = BITS'(SAT_MAX);
    end else if (w_ext < SAT_MIN) begin
      w_red = BITS'(SAT_MIN);
    end else begin
      w_red = BITS'(w_ext);
    end
`else
    w_red = BITS'(w_ext);
`endif
  end

  // Register the decoded sample and its single-cycle valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      x_valid <= 1'b0;
    end else begin
      x_valid <= w_cv[N];
      if (w_cv[N]) begin
        x <= w_red;
      end
    end
  end

endmodule
